// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - per-channel 2-FF sync, counter debounce and press/release edge pulses
// Optional hold detector on btn_long, enabled by BUTTON_CONDITIONER_LONG_PRESS_EN.
module button_conditioner #(
   parameter int N_BTN           = 3,
   parameter int DEBOUNCE_CYCLES = 10000,
   parameter int CNT_W           = 14,
   parameter int LONG_CYCLES     = 1000000,
   parameter int LONG_W          = 20
) (
   input  logic             clk,
   input  logic             res,
   input  logic [N_BTN-1:0] btn_raw,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release,
   output logic [N_BTN-1:0] btn_long
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   // Elaboration-time guard on the legal parameter ranges.
   if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (2**CNT_W) - 1 ||
       LONG_CYCLES < 2 || LONG_CYCLES > 2**LONG_W) begin : g_param_check
      $error("button_conditioner: parameter out of range");
   end

   for (genvar i = 0; i < N_BTN; i++) begin : g_ch
      logic             s1;
      logic             s2;
      logic [CNT_W-1:0] cnt;
      logic             level_q;
      logic             press_q;
      logic             release_q;

      always_ff @(posedge clk or negedge res) begin
         if (!res) begin
            s1        <= 1'b0;
            s2        <= 1'b0;
            cnt       <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
         end else begin
            s1        <= btn_raw[i];
            s2        <= s1;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            if (s2 == level_q) begin
               cnt <= '0;
            end else if (cnt == CNT_LAST) begin
               cnt       <= '0;
               level_q   <= s2;
               press_q   <= s2;
               release_q <= ~s2;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end

      assign btn_level[i]   = level_q;
      assign btn_press[i]   = press_q;
      assign btn_release[i] = release_q;

`ifdef BUTTON_CONDITIONER_LONG_PRESS_EN
      localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);
      localparam logic [LONG_W-1:0] LONG_PRE  = LONG_W'(LONG_CYCLES - 2);

      logic [LONG_W-1:0] lcnt;
      logic              long_q;

      // lcnt is 0 on the edge after the press edge, so reaching LONG_PRE
      // places the pulse exactly LONG_CYCLES edges after the press edge.
      always_ff @(posedge clk or negedge res) begin
         if (!res) begin
            lcnt   <= '0;
            long_q <= 1'b0;
         end else begin
            long_q <= level_q && !press_q && (lcnt == LONG_PRE);
            if (!level_q || press_q) begin
               lcnt <= '0;
            end else if (lcnt != LONG_LAST) begin
               lcnt <= lcnt + 1'b1;
            end
         end
      end

      assign btn_long[i] = long_q;
`else
      assign btn_long[i] = 1'b0;
`endif
   end

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - scoreboard bench for button_conditioner
// Long-press expectations follow BUTTON_CONDITIONER_LONG_PRESS_EN.
module tb_button_conditioner;

   logic       clk = 1'b0;
   logic       res;
   logic [2:0] btn_raw;
   logic [2:0] btn_level;
   logic [2:0] btn_press;
   logic [2:0] btn_release;
   logic [2:0] btn_long;

   int cyc        = 0;
   int vectors    = 0;
   int miscompares = 0;

   typedef struct {
      int         cyc;
      logic [2:0] level;
      logic [2:0] press;
      logic [2:0] rel;
      logic [2:0] lng;
   } ev_t;

   ev_t q[$];

   button_conditioner #(
      .N_BTN(3), .DEBOUNCE_CYCLES(4), .CNT_W(3), .LONG_CYCLES(16), .LONG_W(5)
   ) dut (
      .clk(clk), .res(res), .btn_raw(btn_raw),
      .btn_level(btn_level), .btn_press(btn_press),
      .btn_release(btn_release), .btn_long(btn_long)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Event expected dc negedges from now: drive at this negedge, sampled next edge.
   task automatic expect_ev(input int dc, input logic [2:0] lv, input logic [2:0] pr,
                            input logic [2:0] rl, input logic [2:0] lg);
      ev_t e;
      e.cyc = cyc + dc; e.level = lv; e.press = pr; e.rel = rl; e.lng = lg;
      q.push_back(e);
   endtask

   task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s actual=%h required=%h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: any pulse activity pops one expected event.
   always @(negedge clk) begin
      ev_t e;
      while (q.size() > 0 && q[0].cyc < cyc) begin
         vectors++;
         miscompares++;
         $display("FAIL missed_event required at cyc %0d, actual none", q[0].cyc);
         void'(q.pop_front());
      end
      if ((btn_press | btn_release | btn_long) != 3'b000) begin
         vectors++;
         if (q.size() == 0 || q[0].cyc != cyc) begin
            miscompares++;
            $display("FAIL unexpected_event cyc %0d actual press=%b release=%b long=%b required none",
                     cyc, btn_press, btn_release, btn_long);
         end else begin
            e = q.pop_front();
            if ({btn_level, btn_press, btn_release, btn_long} !== {e.level, e.press, e.rel, e.lng}) begin
               miscompares++;
               $display("FAIL event cyc %0d actual lvl/pr/rl/lg=%b/%b/%b/%b required %b/%b/%b/%b",
                        cyc, btn_level, btn_press, btn_release, btn_long,
                        e.level, e.press, e.rel, e.lng);
            end
         end
      end
   end

   initial begin
      logic pat [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      res = 1'b0;
      btn_raw = 3'b000;
      tick(3);
      check("reset_outputs", {btn_level, btn_press, btn_release, btn_long}, 12'h000);
      res = 1'b1;
      tick(2);

      // single press on channel 0, level at edge 5, pulse gone after edge 6
      btn_raw = 3'b001;
      expect_ev(6, 3'b001, 3'b001, 3'b000, 3'b000);
      tick(7);
      check("ch0_level", {9'd0, btn_level}, {9'd0, 3'b001});
      check("ch0_press_single", {9'd0, btn_press}, 12'h000);

      // asynchronous reset between edges
      #2 res = 1'b0;
      #1 check("async_reset", {btn_level, btn_press, btn_release, btn_long}, 12'h000);
      btn_raw = 3'b000;
      tick(2);
      res = 1'b1;
      tick(2);

      // reset mid-count discards the partial count
      btn_raw = 3'b100;
      tick(3);
      res = 1'b0;
      btn_raw = 3'b000;
      tick(2);
      res = 1'b1;
      tick(8);
      check("midcount_reset_level", {9'd0, btn_level}, 12'h000);

      // glitch rejection on channel 1
      btn_raw = 3'b010;
      tick(3);
      btn_raw = 3'b000;
      tick(4);
      for (int k = 0; k < 6; k++) begin
         btn_raw[1] = pat[k];
         tick(1);
      end
      btn_raw = 3'b000;
      tick(8);
      check("glitch_level", {9'd0, btn_level}, 12'h000);

      // simultaneous press and release on channels 0 and 2
      btn_raw = 3'b101;
      expect_ev(6, 3'b101, 3'b101, 3'b000, 3'b000);
      tick(10);
      check("simul_level", {9'd0, btn_level}, {9'd0, 3'b101});
      btn_raw = 3'b000;
      expect_ev(6, 3'b000, 3'b000, 3'b101, 3'b000);
      tick(10);

      // button held through reset deassertion
      res = 1'b0;
      btn_raw = 3'b010;
      tick(3);
      res = 1'b1;
      expect_ev(6, 3'b010, 3'b010, 3'b000, 3'b000);
      tick(8);
      btn_raw = 3'b000;
      expect_ev(6, 3'b000, 3'b000, 3'b010, 3'b000);
      tick(10);

      // long hold on channel 0
      btn_raw = 3'b001;
      expect_ev(6, 3'b001, 3'b001, 3'b000, 3'b000);
`ifdef BUTTON_CONDITIONER_LONG_PRESS_EN
      expect_ev(22, 3'b001, 3'b000, 3'b000, 3'b001);
`endif
      tick(40);
      check("long_hold_level", {9'd0, btn_level}, {9'd0, 3'b001});
`ifndef BUTTON_CONDITIONER_LONG_PRESS_EN
      check("long_tied_off", {9'd0, btn_long}, 12'h000);
`endif
      btn_raw = 3'b000;
      expect_ev(6, 3'b000, 3'b000, 3'b001, 3'b000);
      tick(10);

      // short hold: no long pulse
      btn_raw = 3'b001;
      expect_ev(6, 3'b001, 3'b001, 3'b000, 3'b000);
      tick(10);
      btn_raw = 3'b000;
      expect_ev(6, 3'b000, 3'b000, 3'b001, 3'b000);
      tick(30);

      while (q.size() > 0) begin
         vectors++;
         miscompares++;
         $display("FAIL missed_event required at cyc %0d, actual none", q[0].cyc);
         void'(q.pop_front());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
